// File: rtl/tx.sv
// Serial transmitter: 8N1/8N2 framing, MSB first, one-entry holding buffer.
// Ports: clk, rst, en, tx_pi/tx_load in; tx_so, tx_busy, tx_ready, tx_done out.
module tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] tx_pi,
  input  logic       tx_load,
  output logic       tx_so,
  output logic       tx_busy,
  output logic       tx_ready,
  output logic       tx_done
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic            full_q, full_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic            so_q, so_d;
  logic            done_q, done_d;

  logic baud_zero;
  logic last_stop;

  assign baud_zero = (baud_q == '0);
  assign last_stop = (stop_q == STOP_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    full_d  = full_q;
    shreg_d = shreg_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    so_d    = so_q;
    // the done pulse never survives an edge, even a frozen one
    done_d  = 1'b0;

    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          so_d = 1'b1;
          if (full_q) begin
            shreg_d = hold_q;
            full_d  = 1'b0;
            baud_d  = BAUD_MAX;
            so_d    = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (baud_zero) begin
            baud_d  = BAUD_MAX;
            so_d    = shreg_q[7];
            bit_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            baud_d = baud_q - BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            shreg_d = shreg_q << 1;
            baud_d  = BAUD_MAX;
            if (bit_q != 3'd7) begin
              // next bit is the one about to move into [7]
              so_d  = shreg_q[6];
              bit_d = bit_q + 3'd1;
            end else begin
              so_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            baud_d = baud_q - BAUD_ONE;
          end
        end
        S_STOP: begin
          if (baud_zero) begin
            if (last_stop) begin
              if (full_q) begin
                // chain straight into the next frame
                shreg_d = hold_q;
                full_d  = 1'b0;
                baud_d  = BAUD_MAX;
                so_d    = 1'b0;
                state_d = S_START;
              end else begin
                so_d    = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              stop_d = 1'b1;
              baud_d = BAUD_MAX;
            end
          end else begin
            baud_d = baud_q - BAUD_ONE;
            // raise done as we enter the final clock
            if (last_stop && baud_q == BAUD_ONE) begin
              done_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // load needs an empty slot, so it never meets a transfer
      if (tx_load && !full_q) begin
        hold_d = tx_pi;
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= 8'h00;
      full_q  <= 1'b0;
      shreg_q <= 8'h00;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      so_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      shreg_q <= shreg_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign tx_so    = so_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign tx_ready = !full_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_tx.sv
// Bench for tx: frame-level timing model plus a byte scoreboard
// fed at load acceptance and drained by a line decoder.
module tb_tx;

  localparam int CPB   = 8;
  localparam int NSTOP = 1;
  localparam int FRAME = (1 + 8 + NSTOP) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] tx_pi = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_so;
  logic       tx_busy;
  logic       tx_ready;
  logic       tx_done;

  int tests = 0;
  int fails = 0;
  bit chk = 1'b0;

  // model: frame clocks left, slot state, bytes
  int         m_left = 0;
  bit         m_full = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] exp_q[$];

  // line decoder state
  bit         in_frame = 1'b0;
  int         k = 0;
  logic [7:0] sh = 8'h00;

  tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(NSTOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .tx_pi(tx_pi),
    .tx_load(tx_load),
    .tx_so(tx_so),
    .tx_busy(tx_busy),
    .tx_ready(tx_ready),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  function automatic logic line_at(int kk,
                                   logic [7:0] b);
    int bi;
    bi = kk / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[8 - bi];
    return 1'b1;
  endfunction

  // advance the model across the edge using
  // the inputs that were applied before it
  task automatic model_step();
    bit xfer;
    bit acc;
    if (rst) begin
      m_full = 1'b0;
      m_left = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else if (en) begin
      xfer = m_full && (m_left <= 1);
      acc  = tx_load && !m_full;
      if (m_left > 0) m_left--;
      if (xfer) begin
        m_left = FRAME;
        m_cur  = m_hold;
        m_full = 1'b0;
      end
      if (acc) begin
        m_hold = tx_pi;
        m_full = 1'b1;
        exp_q.push_back(tx_pi);
      end
      m_done = (m_left == 1);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    tx_pi   = b;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      if (m_left == 0 && !m_full) break;
      tick();
    end
  endtask

  // monitor: cycle-level outputs vs model,
  // decoded bytes vs scoreboard on tx_done
  initial begin
    logic [3:0] got;
    logic [3:0] exp;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (chk) begin
        got = {tx_so, tx_busy, tx_ready, tx_done};
        exp = {(m_left == 0) ? 1'b1 :
               line_at(FRAME - m_left, m_cur),
               m_left != 0, !m_full, m_done};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL cycle t=%0t so/busy/rdy/done got %b exp %b",
                   $time, got, exp);
        end
        if (rst) begin
          in_frame = 1'b0;
        end else begin
          if (!in_frame && tx_so == 1'b0) begin
            in_frame = 1'b1;
            k = 0;
          end
          if (in_frame && tx_done) begin
            in_frame = 1'b0;
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL frame_unexpected got %h exp none",
                       sh);
            end else begin
              eb = exp_q.pop_front();
              if (sh !== eb) begin
                fails++;
                $display("FAIL frame_byte got %h exp %h",
                         sh, eb);
              end
            end
            tests++;
            if (k != FRAME - 1) begin
              fails++;
              $display("FAIL frame_len got %0d exp %0d",
                       k + 1, FRAME);
            end
          end else if (in_frame && en) begin
            if (k % CPB == CPB / 2 &&
                k / CPB >= 1 && k / CPB <= 8)
              sh = {sh[6:0], tx_so};
            k++;
            if (k > FRAME + 2) begin
              in_frame = 1'b0;
              tests++;
              fails++;
              $display("FAIL frame_no_done got %0d exp %0d",
                       k, FRAME);
            end
          end
        end
      end
    end
  end

  initial begin
    // reset and idle
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk = 1'b1;
    repeat (20) tick();

    // single byte
    load(8'hA5);
    wait_idle();
    repeat (4) tick();

    // back-to-back
    load(8'h3C);
    repeat (3) tick();
    load(8'hC3);
    wait_idle();
    repeat (4) tick();

    // overrun: third load must be dropped
    load(8'h11);
    repeat (3) tick();
    load(8'h22);
    repeat (3) tick();
    load(8'h33);
    wait_idle();
    repeat (4) tick();

    // enable freeze inside data bit 3
    load(8'h5A);
    tick();
    repeat (27) tick();
    en = 1'b0;
    repeat (20) tick();
    en = 1'b1;
    wait_idle();
    repeat (4) tick();

    // reset mid-frame with a byte buffered
    load(8'h77);
    tick();
    load(8'h88);
    repeat (43) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (100) tick();

    // randomized traffic, enable gaps, rare resets
    for (int i = 0; i < 6000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      tx_load = ($urandom_range(0, 29) == 0);
      tx_pi   = 8'($urandom);
      rst     = ($urandom_range(0, 1999) == 0);
      tick();
    end
    en      = 1'b1;
    tx_load = 1'b0;
    rst     = 1'b0;
    wait_idle();
    repeat (5) tick();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover got %0d bytes exp 0",
               exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/tx.md
# tx

Serial transmitter and the sending end of the link whose receiver is `rx`. The block accepts a byte over a parallel load handshake and buffers it in a one-entry holding register. It then shifts the byte out on a single line: one start bit (low), eight data bits MSB first, and 1 or 2 stop bits (high). Each bit lasts `CLKS_PER_BIT` clocks. With default parameters, `rx` on the far end recovers the byte bit-exact.

## Interface
- `CLKS_PER_BIT`, default 8: clocks per bit period. Legal range is ≥2. The default matches the receiver's 8-clock bit period.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high. It overrides `en`.
- `en` in 1: clock enable. When low, all state is frozen.
- `tx_pi` in 8: parallel input byte.
- `tx_load` in 1: load strobe. It is sampled only when `en=1` and `tx_ready=1`.
- `tx_so` out 1: serial output, registered. It idles high.
- `tx_busy` out 1: high while a frame is on the line.
- `tx_ready` out 1: holding register empty, so a new byte can be accepted.
- `tx_done` out 1: one-cycle pulse on the last clock of a frame's final stop bit.

## Operation
- **Registers:**
  - holding register `hold[7:0]` with flag `hold_full`.
  - shift register `shreg[7:0]`.
  - baud counter of `$clog2(CLKS_PER_BIT)` bits, counting down from `CLKS_PER_BIT-1` to 0.
  - 3-bit data bit counter.
  - 1-bit stop counter.
- **Outputs:**
  - `tx_ready = !hold_full`, registered.
  - `tx_busy = 1` in START, DATA and STOP.
- **Load:** `tx_load=1` with `tx_ready=1` and `en=1` captures `tx_pi` into `hold` and sets `hold_full`. A load while `tx_ready=0` is ignored, with no error and no overwrite.
- **IDLE:**
  - `tx_so=1`.
  - If `hold_full`: `shreg<=hold`, clear `hold_full`, reload the baud counter, set `tx_so<=0`, go to START.
- **START:** when baud count hits 0, reload it, `tx_so<=shreg[7]`, go to DATA.
- **DATA:**
  - Each time the baud count hits 0, shift `shreg` left.
  - If the bit counter is below 7: drive the next bit and increment the bit counter.
  - After the 8th bit: `tx_so<=1` and go to STOP.
- **STOP:**
  - Lasts `STOP_BITS*CLKS_PER_BIT` clocks.
  - On its last clock, `tx_done<=1`.
  - If `hold_full` at that point: transfer `hold` to `shreg` and go straight to START with `tx_so<=0`, leaving no idle gap.
  - Otherwise go to IDLE.
- **Enable:** `en=0` freezes the state, counters, `shreg`, `hold` and `tx_so`. `tx_load` is ignored while `en=0`.
- **`tx_done` clearing:** `tx_done` clears at the next clock edge regardless of `en`.
- **Reset (`rst=1`), applied at the edge:**
  - state=IDLE and `tx_so=1`.
  - `tx_busy=0`, `tx_ready=1`, `tx_done=0`.
  - `hold_full=0` and all counters cleared.
  - A frame in progress is aborted, and any buffered byte is discarded.

## Timing
- **Load to start bit:** a load accepted at edge N gives `tx_ready=0` after N. If the block was idle, the start bit appears on `tx_so` after edge N+1, at which point `tx_ready` returns to 1 and `tx_busy` rises.
- **Frame length:** `(1+8+STOP_BITS)*CLKS_PER_BIT` enabled clocks, i.e. 80 with the defaults.
- **Back-to-back:** a byte buffered during a frame starts exactly at the end of the previous stop bit. Consecutive `tx_done` pulses are then one frame length apart.
- **`tx_done`:** high for exactly one clock, on the final clock of STOP.
- **Simultaneous events:** a load cannot coincide with a hold-to-shift transfer, because a load requires `hold_full=0`. A load on the edge immediately after a transfer is accepted.
- **Enable gaps:** each cycle with `en=0` extends the current bit by one clock and keeps its level.

## Test plan
1. **Reset:** `rst=1` for 2 clocks, then 0 → `tx_so=1`, `tx_busy=0`, `tx_ready=1`, `tx_done=0`. They stay that way for 20 idle clocks.
2. **Single byte:** load 0xA5 → the line shows 0 for 8 clocks, then bits 1,0,1,0,0,1,0,1 for 8 clocks each, then 1 for 8 clocks. `tx_done` is high on clock 80 of the frame. In loopback to `rx` (ack held high), `rx_po=0xA5` and `rx_error=0`.
3. **Back-to-back:** load 0x3C, then load 0xC3 while busy (`tx_ready=1` after the transfer) → the second start bit immediately follows the first stop bit. Two `tx_done` pulses 80 clocks apart; `tx_busy` never drops between frames.
4. **Overrun:** load 0x11 and 0x22, then 0x33 while `tx_ready=0` → only 0x11 and 0x22 are transmitted, and 0x33 is dropped.
5. **Enable freeze:** drop `en` for 20 clocks during data bit 3 → `tx_so` holds its level. The frame ends on clock 100 and the transmitted byte is unchanged.
6. **Reset mid-frame:** assert `rst` during data bit 5 with a byte buffered → `tx_so=1` and `tx_ready=1` after the edge. No `tx_done`, and the buffered byte is never sent.
